algofoogle_product_driver: RTL

Host-side initiator for the nibble-serial 12x12 multiplier tile.
- Accepts two operands over a valid/ready request interface.
- Serialises them as nibbles into the tile, then deserialises the product bytes the tile streams back.
- Delivers the full product as a single response pulse.
- Shares the tile's clock and mirrors its phase counter, so no handshake is needed on the tile side.

---
 rtl/algofoogle_product_pkg.sv | 27 ++
 rtl/algofoogle_nibble_serializer.sv | 46 ++++
 rtl/algofoogle_product_driver.sv | 134 +++++++++++++
 3 files changed

// File: rtl/algofoogle_product_pkg.sv
// Shared widths and types for the nibble-serial 12x12 multiplier tile and
// its host-side driver. Both sides import this so their widths stay locked.
package algofoogle_product_pkg;

  localparam int OP_NIBBLES   = 3;
  localparam int OP_BITS      = 4 * OP_NIBBLES;
  localparam int MUL_BITS     = 2 * OP_BITS;
  localparam int PHASES       = 3 * OP_NIBBLES;
  localparam int PAIR_NIBBLES = 2 * OP_NIBBLES;
  localparam int PHASE_BITS   = $clog2(PHASES);
  // Product bytes captured before the final byte arrives on the completion edge.
  localparam int CAPTURE_BITS = MUL_BITS - 8;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } drv_state_t;

  typedef logic [PHASE_BITS-1:0] phase_t;

  // Nibble idx of an operand pair, counting from the MS nibble (idx 0).
  function automatic logic [3:0] pair_nibble(input logic [2*OP_BITS-1:0] pair,
                                             input int idx);
    return pair[(2*OP_BITS-1) - 4*idx -: 4];
  endfunction

endpackage

// File: rtl/algofoogle_nibble_serializer.sv
// Loads an operand pair {a, b} and presents it one nibble per shift,
// MS nibble of a first. The presented nibble is a register output.
module algofoogle_nibble_serializer
  import algofoogle_product_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic [OP_BITS-1:0] load_a,
  input  logic [OP_BITS-1:0] load_b,
  output logic [3:0]         nibble
);

  logic [2*OP_BITS-1:0] pair;
  logic [3:0]           stage_reg [PAIR_NIBBLES];

  assign pair = {load_a, load_b};

  generate
    for (genvar gi = 0; gi < PAIR_NIBBLES; gi++) begin : g_stage
      logic [3:0] shift_in;

      if (gi == PAIR_NIBBLES - 1) begin : g_tail
        // Zeros fill in behind the last nibble.
        assign shift_in = 4'd0;
      end else begin : g_body
        assign shift_in = stage_reg[gi+1];
      end

      // Stage gi holds nibble gi of the pair; a shift moves everything one stage toward the output.
      always_ff @(posedge clk) begin
        if (reset) begin
          stage_reg[gi] <= 4'd0;
        end else if (load) begin
          stage_reg[gi] <= pair_nibble(pair, gi);
        end else if (shift) begin
          stage_reg[gi] <= shift_in;
        end
      end
    end
  endgenerate

  assign nibble = stage_reg[0];

endmodule

// File: rtl/algofoogle_product_driver.sv
// Host-side initiator for the nibble-serial multiplier tile. Accepts an
// operand pair, feeds it to the tile nibble by nibble, collects the product
// bytes the tile streams back and emits the product as a one-cycle pulse.
// The tile free-runs on the same clock, so a local phase counter mirrors it.
module algofoogle_product_driver
  import algofoogle_product_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OP_BITS-1:0]  req_a,
  input  logic [OP_BITS-1:0]  req_b,
  output logic                rsp_valid,
  output logic [MUL_BITS-1:0] rsp_product,
  output logic                tgt_reset,
  output logic [3:0]          tgt_nibble,
  input  logic [7:0]          tgt_byte
);

  localparam phase_t LAST_PHASE  = phase_t'(PHASES - 1);
  localparam phase_t SHIFT_LIMIT = phase_t'(2*OP_NIBBLES - 1);
  localparam phase_t CAP_FIRST   = phase_t'(2*OP_NIBBLES + 1);

  drv_state_t              state_reg, state_next;
  phase_t                  phase_reg, phase_next;
  logic                    tgt_reset_next;
  logic                    last_pending_reg, last_pending_next;
  logic [CAPTURE_BITS-1:0] capture_reg, capture_next;
  logic                    rsp_valid_next;
  logic [MUL_BITS-1:0]     rsp_product_next;
  logic                    accept;
  logic                    shift_ser;

  // A new request fits while idle or on the final phase, giving back-to-back issue.
  always_comb begin
    req_ready = (state_reg == ST_IDLE) ||
                ((state_reg == ST_RUN) && (phase_reg == LAST_PHASE));
    accept    = req_valid && req_ready;
  end

  algofoogle_nibble_serializer u_serializer (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .shift  (shift_ser),
    .load_a (req_a),
    .load_b (req_b),
    .nibble (tgt_nibble)
  );

  // Next-state and datapath updates for the phase-locked sequencer.
  always_comb begin
    state_next        = state_reg;
    phase_next        = phase_reg;
    tgt_reset_next    = tgt_reset;
    last_pending_next = last_pending_reg;
    capture_next      = capture_reg;
    rsp_valid_next    = 1'b0;
    rsp_product_next  = rsp_product;
    shift_ser         = 1'b0;

    // The last product byte is on tgt_byte one edge after the final phase,
    // whether the tile is being parked or already starting the next operand.
    if (last_pending_reg) begin
      rsp_product_next  = {capture_reg, tgt_byte};
      rsp_valid_next    = 1'b1;
      last_pending_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        tgt_reset_next = 1'b1;
        if (accept) begin
          tgt_reset_next = 1'b0;
          phase_next     = '0;
          state_next     = ST_RUN;
        end
      end

      ST_RUN: begin
        phase_next = (phase_reg == LAST_PHASE) ? '0 : phase_reg + 1'b1;

        // The first nibble was presented at load; the rest follow while the tile shifts.
        if (phase_reg < SHIFT_LIMIT) begin
          shift_ser = 1'b1;
        end

        if (phase_reg >= CAP_FIRST) begin
          capture_next = {capture_reg[CAPTURE_BITS-9:0], tgt_byte};
        end

        if (phase_reg == LAST_PHASE) begin
          last_pending_next = 1'b1;
          if (accept) begin
            tgt_reset_next = 1'b0;
            state_next     = ST_RUN;
          end else begin
            // Park the tile; it cannot be paused any other way.
            tgt_reset_next = 1'b1;
            state_next     = ST_IDLE;
          end
        end
      end

      default: begin
        state_next     = ST_IDLE;
        tgt_reset_next = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      phase_reg        <= '0;
      tgt_reset        <= 1'b1;
      last_pending_reg <= 1'b0;
      capture_reg      <= '0;
      rsp_valid        <= 1'b0;
      rsp_product      <= '0;
    end else begin
      state_reg        <= state_next;
      phase_reg        <= phase_next;
      tgt_reset        <= tgt_reset_next;
      last_pending_reg <= last_pending_next;
      capture_reg      <= capture_next;
      rsp_valid        <= rsp_valid_next;
      rsp_product      <= rsp_product_next;
    end
  end

endmodule
